mem_access_unit: RTL and testbench

- CPU-side initiator for the data memory port. It accepts one load/store request at a time from the execute stage and drives the memory's addr/din/memOp/we interface.
- The memory itself only handles accesses contained in one 32-bit word. This block splits word-boundary-crossing loads into two aligned word reads and crossing stores into a byte-store sequence.
- It reassembles and sign-extends load data, then returns a one-cycle response.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a word-wide data memory.
// Word-crossing loads are split into two aligned reads; crossing stores become byte-store sequences.
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [2:0]            mem_memOp,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_A     = 3'd1,
    S_LOAD_B     = 3'd2,
    S_LOAD_FIN   = 3'd3,
    S_STORE      = 3'd4,
    S_STORE_BYTE = 3'd5,
    S_RESP       = 3'd6
  } state_e;

  localparam logic [2:0] OP_SB = 3'd0;
  localparam logic [2:0] OP_LW = 3'd2;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              op_q, op_d;
  logic                    cross_q, cross_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              cnt_q, cnt_d;

  // Access width minus one in bytes: 0 (byte), 1 (half) or 3 (word).
  function automatic logic [1:0] width_m1(input logic [2:0] op);
    case (op[1:0])
      2'd0:    width_m1 = 2'd0;
      2'd1:    width_m1 = 2'd1;
      default: width_m1 = 2'd3;
    endcase
  endfunction

  logic                    req_cross;
  logic                    split;
  logic [1:0]              wm1_q;
  logic                    sign_ext;
  logic [ADDR_WIDTH-1:0]   aligned;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   joined;

  assign req_cross = ({1'b0, req_addr[1:0]} + {1'b0, width_m1(req_op)}) >= 3'd4;
  assign split     = cross_q && SPLIT_EN;
  assign wm1_q     = width_m1(op_q);
  assign sign_ext  = (op_q == 3'd0) || (op_q == 3'd1);
  assign aligned   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign pair      = {mem_dout, lo_q};
  assign shifted   = pair[{addr_q[1:0], 3'b000} +: DATA_WIDTH];

  // Only halves and words can cross, so byte extraction is never needed here.
  always_comb begin
    joined = shifted;
    if (wm1_q == 2'd1) begin
      joined = sign_ext ? {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]}
                        : {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_LW;
      cross_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      cross_q <= cross_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    op_d            = op_q;
    cross_d         = cross_q;
    lo_d            = lo_q;
    rdata_d         = rdata_q;
    cnt_d           = cnt_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    mem_addr        = '0;
    mem_din         = '0;
    mem_memOp       = OP_LW;
    mem_we          = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          op_d    = req_op;
          cross_d = req_cross;
          cnt_d   = 2'd0;
          rdata_d = '0;
          if (!req_store)                  state_d = S_LOAD_A;
          else if (req_cross && SPLIT_EN)  state_d = S_STORE_BYTE;
          else                             state_d = S_STORE;
        end
      end
      S_LOAD_A: begin
        if (split) begin
          mem_addr  = aligned;
          mem_memOp = OP_LW;
          state_d   = S_LOAD_B;
        end else begin
          mem_addr  = addr_q;
          mem_memOp = op_q;
          state_d   = S_LOAD_FIN;
        end
      end
      S_LOAD_B: begin
        lo_d      = mem_dout;
        mem_addr  = aligned + ADDR_WIDTH'(4);
        mem_memOp = OP_LW;
        state_d   = S_LOAD_FIN;
      end
      S_LOAD_FIN: begin
        // Unsplit reads come back already extended by the memory.
        rdata_d = split ? joined : mem_dout;
        state_d = S_RESP;
      end
      S_STORE: begin
        mem_addr  = addr_q;
        mem_din   = wdata_q;
        mem_memOp = op_q;
        mem_we    = 1'b1;
        state_d   = S_RESP;
      end
      S_STORE_BYTE: begin
        mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
        mem_din   = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        mem_memOp = OP_SB;
        mem_we    = 1'b1;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == wm1_q) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid      = 1'b1;
        resp_rdata      = rdata_q;
        resp_misaligned = cross_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a byte-array memory model.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'd2;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        req_ready0, resp_valid0, resp_mis0, mem_we0;
  logic [31:0] resp_rdata0, mem_addr0, mem_din0, mem_dout0;
  logic [2:0]  mem_memOp0;
  logic        req_ready1, resp_valid1, resp_mis1, mem_we1;
  logic [31:0] resp_rdata1, mem_addr1, mem_din1, mem_dout1;
  logic [2:0]  mem_memOp1;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_store(req_store), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_misaligned(resp_mis0),
    .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_memOp(mem_memOp0), .mem_we(mem_we0),
    .mem_dout(mem_dout0));

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SPLIT_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_store(1'b0), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_misaligned(resp_mis1),
    .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_memOp(mem_memOp1), .mem_we(mem_we1),
    .mem_dout(mem_dout1));

  // Memory model: word-contained accesses only, registered read, truncating shifted data.
  logic [7:0] m [0:511];

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] wd, sh;
    logic [8:0]  b;
    b  = {a[8:2], 2'b00};
    wd = {m[b+9'd3], m[b+9'd2], m[b+9'd1], m[b]};
    sh = wd >> (8 * a[1:0]);
    case (op)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'b0, sh[7:0]};
      3'd5:    return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  task automatic wr(input logic [31:0] a, input logic [2:0] op, input logic [31:0] din);
    int w, off;
    w   = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    for (int j = 0; j < w; j++)
      if (off + j < 4) m[{a[8:2], 2'b00} + 9'(off + j)] = din[8*j +: 8];
  endtask

  always @(posedge clk) begin
    mem_dout0 <= rd(mem_addr0, mem_memOp0);
    mem_dout1 <= rd(mem_addr1, mem_memOp1);
    if (mem_we0) wr(mem_addr0, mem_memOp0, mem_din0);
  end

  task automatic preload();
    for (int i = 0; i < 512; i++) m[i] = 8'h00;
    {m[259], m[258], m[257], m[256]} = 32'h44332211;
    {m[263], m[262], m[261], m[260]} = 32'h887766F5;
  endtask

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] acc_addr [1:10];
  logic [31:0] acc_din  [1:10];
  logic [2:0]  acc_op   [1:10];
  logic        acc_we   [1:10];
  int          lat;
  logic [31:0] r_rdata;
  logic        r_mis;

  // Issue one request on dut0 (sel=0) or dut1 (sel=1); record memory traffic per cycle after acceptance.
  task automatic do_req(input bit sel, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_store = st; req_op = op; req_addr = a; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    chk("ready_before_accept", {31'b0, sel ? req_ready1 : req_ready0}, 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    lat = 0; r_rdata = 'x; r_mis = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      acc_addr[c] = sel ? mem_addr1 : mem_addr0;
      acc_din[c]  = sel ? mem_din1 : mem_din0;
      acc_op[c]   = sel ? mem_memOp1 : mem_memOp0;
      acc_we[c]   = sel ? mem_we1 : mem_we0;
      if ((sel ? resp_valid1 : resp_valid0) && lat == 0) begin
        lat     = c;
        r_rdata = sel ? resp_rdata1 : resp_rdata0;
        r_mis   = sel ? resp_mis1 : resp_mis0;
        break;
      end
    end
  endtask

  logic [31:0] bytes;
  logic        saw_resp;

  initial begin
    preload();
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready0}, 32'd1);
    chk("rst_addr", mem_addr0, 32'h0);
    chk("rst_din", mem_din0, 32'h0);
    chk("rst_op", {29'b0, mem_memOp0}, 32'd2);
    chk("rst_we", {31'b0, mem_we0}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid0, resp_mis0}, 32'd0);
    chk("rst_rdata", resp_rdata0, 32'h0);
    rst = 1'b0;

    // SPLIT_EN=0: crossing word load passes through as one truncated access.
    do_req(1'b1, 1'b0, 3'd2, 32'h101, 32'h0);
    chk("ns_lat", lat, 3);
    chk("ns_addr", acc_addr[1], 32'h101);
    chk("ns_op", {29'b0, acc_op[1]}, 32'd2);
    chk("ns_mis", {31'b0, r_mis}, 32'd1);
    chk("ns_rdata", r_rdata, 32'h00443322);

    // Split crossing loads.
    do_req(1'b0, 1'b0, 3'd2, 32'h101, 32'h0);
    chk("lw101_lat", lat, 4);
    chk("lw101_a1", acc_addr[1], 32'h100);
    chk("lw101_a2", acc_addr[2], 32'h104);
    chk("lw101_ops", {26'b0, acc_op[1], acc_op[2]}, {26'b0, 3'd2, 3'd2});
    chk("lw101_rdata", r_rdata, 32'hF5443322);
    chk("lw101_mis", {31'b0, r_mis}, 32'd1);

    do_req(1'b0, 1'b0, 3'd1, 32'h103, 32'h0);
    chk("lh103_rdata", r_rdata, 32'hFFFFF544);
    chk("lh103_lat", lat, 4);
    do_req(1'b0, 1'b0, 3'd5, 32'h103, 32'h0);
    chk("lhu103_rdata", r_rdata, 32'h0000F544);
    do_req(1'b0, 1'b0, 3'd0, 32'h107, 32'h0);
    chk("lb107_rdata", r_rdata, 32'hFFFFFF88);
    chk("lb107_mis", {31'b0, r_mis}, 32'd0);
    chk("lb107_lat", lat, 3);

    // Crossing word store becomes four byte stores.
    do_req(1'b0, 1'b1, 3'd2, 32'h102, 32'hAABBCCDD);
    chk("sw102_lat", lat, 5);
    chk("sw102_mis", {31'b0, r_mis}, 32'd1);
    chk("sw102_rdata", r_rdata, 32'h0);
    bytes = 32'hAABBCCDD;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sw102_addr%0d", c), acc_addr[c], 32'h101 + 32'(c));
      chk($sformatf("sw102_din%0d", c), acc_din[c], {24'b0, bytes[8*(c-1) +: 8]});
      chk($sformatf("sw102_opwe%0d", c), {28'b0, acc_op[c], acc_we[c]}, {28'b0, 3'd0, 1'b1});
    end
    chk("sw102_we_resp", {31'b0, acc_we[5]}, 32'd0);
    do_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
    chk("after_sw_100", r_rdata, 32'hCCDD2211);
    do_req(1'b0, 1'b0, 3'd2, 32'h104, 32'h0);
    chk("after_sw_104", r_rdata, 32'h8877AABB);

    // Aligned store with req_valid held high straight into a following load.
    @(negedge clk);
    req_store = 1'b1; req_op = 3'd2; req_addr = 32'h108; req_wdata = 32'h12345678;
    req_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_c1_ready", {31'b0, req_ready0}, 32'd0);
    chk("hold_c1_we", {31'b0, mem_we0}, 32'd1);
    chk("hold_c1_addr", mem_addr0, 32'h108);
    chk("hold_c1_din", mem_din0, 32'h12345678);
    chk("hold_c1_resp", {31'b0, resp_valid0}, 32'd0);
    @(negedge clk);
    chk("hold_c2_ready", {31'b0, req_ready0}, 32'd0);
    chk("hold_c2_resp", {31'b0, resp_valid0}, 32'd1);
    chk("hold_c2_we", {31'b0, mem_we0}, 32'd0);
    req_store = 1'b0;
    @(negedge clk);
    chk("hold_c3_ready", {31'b0, req_ready0}, 32'd1);
    @(negedge clk);
    chk("hold_c4_ready", {31'b0, req_ready0}, 32'd0);
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("hold_c5_resp", {31'b0, resp_valid0}, 32'd0);
    @(negedge clk);
    chk("hold_c6_resp", {31'b0, resp_valid0}, 32'd1);
    chk("hold_c6_rdata", resp_rdata0, 32'h12345678);

    // Reset in the middle of a byte-store sequence.
    preload();
    @(negedge clk);
    req_store = 1'b1; req_op = 3'd2; req_addr = 32'h102; req_wdata = 32'hAABBCCDD;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_before", {31'b0, mem_we0}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'b0, mem_we0}, 32'd0);
    chk("abort_resp", {31'b0, resp_valid0}, 32'd0);
    saw_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid0;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_resp = saw_resp | resp_valid0;
    end
    chk("abort_no_resp", {31'b0, saw_resp}, 32'd0);
    chk("abort_ready", {31'b0, req_ready0}, 32'd1);
    do_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0);
    chk("abort_100", r_rdata, 32'hCCDD2211);
    do_req(1'b0, 1'b0, 3'd2, 32'h104, 32'h0);
    chk("abort_104", r_rdata, 32'h887766F5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
